// File: rtl/clk_lock_monitor.sv
// Multi-channel reference-clock lock monitor: measures the period between
// synchronized reference rising edges and qualifies lock on consecutive matches.
module clk_lock_monitor #(
    parameter int CHANNELS    = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int TOL_SHIFT   = 6,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [CHANNELS-1:0]             ref_i,
    input  logic [CHANNELS-1:0]             clear_i,
    output logic [CHANNELS-1:0]             lock_o,
    output logic [CHANNELS*CNT_WIDTH-1:0]   period_o,
    output logic [CHANNELS-1:0]             period_valid_o,
    output logic [CHANNELS-1:0]             timeout_o
);

    // state  | meaning
    // IDLE   | no history; waiting for the first reference edge
    // ARMED  | one edge seen; the next edge yields the first period
    // TRACK  | periods reported; counting consecutive matches
    // LOCKED | LOCK_COUNT consecutive matches seen; lock_o asserted
    typedef enum logic [1:0] {IDLE, ARMED, TRACK, LOCKED} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_TC = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [3:0]           LOCK_TC    = 4'(LOCK_COUNT);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   synced_d_q;
        logic [CNT_WIDTH-1:0]   cnt_q;
        logic [CNT_WIDTH-1:0]   prev_q;
        logic [CNT_WIDTH-1:0]   period_q;
        logic [3:0]             match_cnt_q;
        logic                   lock_q;
        logic                   valid_q;
        logic                   timeout_q;
        state_t                 state_q;

        logic                   edge_det;
        logic                   cnt_sat;
        logic [CNT_WIDTH-1:0]   meas;
        logic [CNT_WIDTH:0]     diff;
        logic                   match;
        logic                   timeout_hit;
        logic [3:0]             match_cnt_inc;

        assign edge_det      = sync_q[SYNC_STAGES-1] & ~synced_d_q;
        assign cnt_sat       = (cnt_q == CNT_MAX);
        assign meas          = cnt_sat ? CNT_MAX : cnt_q + 1'b1;
        assign diff          = (meas >= prev_q) ? ({1'b0, meas} - {1'b0, prev_q})
                                                : ({1'b0, prev_q} - {1'b0, meas});
        // An all-ones measurement means the counter ran out, so it is never trusted.
        assign match         = (meas != CNT_MAX) && (diff <= {1'b0, prev_q >> TOL_SHIFT});
        assign timeout_hit   = (state_q != IDLE) && !edge_det && (cnt_q == TIMEOUT_TC);
        assign match_cnt_inc = match_cnt_q + 4'd1;

        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                sync_q      <= '0;
                synced_d_q  <= 1'b0;
                cnt_q       <= '0;
                prev_q      <= '0;
                period_q    <= '0;
                match_cnt_q <= '0;
                lock_q      <= 1'b0;
                valid_q     <= 1'b0;
                timeout_q   <= 1'b0;
                state_q     <= IDLE;
            end else begin
                sync_q     <= {sync_q[SYNC_STAGES-2:0], ref_i[n]};
                synced_d_q <= sync_q[SYNC_STAGES-1];
                valid_q    <= 1'b0;
                if (clear_i[n]) begin
                    state_q     <= IDLE;
                    lock_q      <= 1'b0;
                    timeout_q   <= 1'b0;
                    cnt_q       <= '0;
                    match_cnt_q <= '0;
                end else begin
                    if (edge_det) begin
                        cnt_q <= '0;
                    end else if (!cnt_sat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end

                    if (edge_det) begin
                        case (state_q)
                            IDLE: state_q <= ARMED;
                            ARMED: begin
                                prev_q      <= meas;
                                period_q    <= meas;
                                valid_q     <= 1'b1;
                                match_cnt_q <= '0;
                                state_q     <= TRACK;
                            end
                            TRACK: begin
                                prev_q   <= meas;
                                period_q <= meas;
                                valid_q  <= 1'b1;
                                if (match) begin
                                    match_cnt_q <= match_cnt_inc;
                                    if (match_cnt_inc == LOCK_TC) begin
                                        state_q <= LOCKED;
                                        lock_q  <= 1'b1;
                                    end
                                end else begin
                                    match_cnt_q <= '0;
                                end
                            end
                            LOCKED: begin
                                prev_q   <= meas;
                                period_q <= meas;
                                valid_q  <= 1'b1;
                                if (!match) begin
                                    state_q     <= TRACK;
                                    lock_q      <= 1'b0;
                                    match_cnt_q <= '0;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else if (timeout_hit) begin
                        state_q     <= IDLE;
                        lock_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                        match_cnt_q <= '0;
                    end
                end
            end
        end

        assign lock_o[n]                           = lock_q;
        assign period_valid_o[n]                   = valid_q;
        assign timeout_o[n]                        = timeout_q;
        assign period_o[n*CNT_WIDTH +: CNT_WIDTH]  = period_q;
    end

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Randomized bench for clk_lock_monitor: a time-based behavioural model is
// compared every cycle, plus literal checks for the key lock/timeout scenarios.
module tb_clk_lock_monitor;

    localparam int CH  = 2;
    localparam int W   = 16;
    localparam int TOL = 6;
    localparam int LC  = 4;
    localparam int TMO = 1000;
    localparam int SS  = 2;
    localparam int MAXC = (1 << W) - 1;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [CH-1:0]     ref_i;
    logic [CH-1:0]     clear_i;
    logic [CH-1:0]     lock_o;
    logic [CH*W-1:0]   period_o;
    logic [CH-1:0]     period_valid_o;
    logic [CH-1:0]     timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    clk_lock_monitor #(
        .CHANNELS(CH), .CNT_WIDTH(W), .TOL_SHIFT(TOL),
        .LOCK_COUNT(LC), .TIMEOUT(TMO), .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .ref_i(ref_i), .clear_i(clear_i),
        .lock_o(lock_o), .period_o(period_o),
        .period_valid_o(period_valid_o), .timeout_o(timeout_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    endtask

    // Reference generator controls (written by main at posedge, read at negedge).
    int en[CH], per[CH], jit[CH], cd[CH], hi[CH];
    int fq0[$];

    initial begin
        logic [CH-1:0] bits;
        bits  = '0;
        ref_i = '0;
        forever begin
            @(negedge clk_i);
            for (int c = 0; c < CH; c++) begin
                if (en[c] == 0) begin
                    bits[c] = 1'b0;
                    cd[c]   = 1;
                    hi[c]   = 0;
                end else if (cd[c] <= 1) begin
                    bits[c] = 1'b1;
                    hi[c]   = 3;
                    if (c == 0 && fq0.size() > 0) cd[c] = fq0.pop_front();
                    else cd[c] = per[c] + ((jit[c] != 0) ? int'($urandom_range(0, 2)) - 1 : 0);
                end else begin
                    cd[c]--;
                    if (hi[c] > 0) hi[c]--;
                    bits[c] = (hi[c] > 0);
                end
            end
            ref_i = bits;
        end
    end

    // Behavioural model: edges are times, a period is a time difference, and a
    // channel is locked once its run of consecutive agreeing periods reaches LC.
    int  t = 0;
    bit  model_ok = 0;
    bit  hist[CH][SS+1];
    int  edges_seen[CH], run[CH], last_t[CH], prevp[CH], exp_per[CH];
    bit  exp_valid[CH], exp_tmo[CH], exp_lock[CH];

    initial begin
        forever begin
            @(posedge clk_i);
            t++;
            for (int c = 0; c < CH; c++) begin
                bit ev;
                int meas, d;
                ev = hist[c][SS-1] && !hist[c][SS];
                for (int j = SS; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = ref_i[c];
                exp_valid[c] = 1'b0;
                if (!rstn_i) begin
                    for (int j = 0; j <= SS; j++) hist[c][j] = 1'b0;
                    edges_seen[c] = 0; run[c] = 0; last_t[c] = t;
                    prevp[c] = 0; exp_per[c] = 0; exp_tmo[c] = 1'b0;
                end else if (clear_i[c]) begin
                    edges_seen[c] = 0; run[c] = 0; last_t[c] = t; exp_tmo[c] = 1'b0;
                end else if (ev) begin
                    meas = t - last_t[c];
                    if (meas > MAXC) meas = MAXC;
                    last_t[c] = t;
                    if (edges_seen[c] == 0) begin
                        edges_seen[c] = 1;
                    end else begin
                        if (edges_seen[c] == 1) begin
                            edges_seen[c] = 2;
                            run[c] = 0;
                        end else begin
                            d = (meas > prevp[c]) ? meas - prevp[c] : prevp[c] - meas;
                            if (meas != MAXC && d <= (prevp[c] >> TOL)) run[c]++;
                            else run[c] = 0;
                        end
                        prevp[c] = meas;
                        exp_per[c] = meas;
                        exp_valid[c] = 1'b1;
                    end
                end else if (edges_seen[c] > 0 && (t - last_t[c]) == TMO) begin
                    edges_seen[c] = 0; run[c] = 0; exp_tmo[c] = 1'b1;
                end
                exp_lock[c] = (edges_seen[c] == 2) && (run[c] >= LC);
            end
            if (!rstn_i) model_ok = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (model_ok) begin
                for (int c = 0; c < CH; c++) begin
                    check($sformatf("model lock[%0d]", c), lock_o[c], exp_lock[c]);
                    check($sformatf("model valid[%0d]", c), period_valid_o[c], exp_valid[c]);
                    check($sformatf("model timeout[%0d]", c), timeout_o[c], exp_tmo[c]);
                    check($sformatf("model period[%0d]", c), period_o[c*W +: W], exp_per[c]);
                end
            end
        end
    end

    task automatic wait_pulse(input int c, input int limit, output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < limit) begin
            @(negedge clk_i);
            cycles++;
            got = period_valid_o[c];
        end
        if (!got) check($sformatf("pulse wait ch%0d", c), 0, 1);
    endtask

    initial begin
        int  cyc, len, cl, clch;
        bit  found, prev_r;
        for (int c = 0; c < CH; c++) begin
            en[c] = 0; per[c] = 100; jit[c] = 0;
        end
        rstn_i  = 1'b0;
        clear_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset lock", lock_o, 0);
        check("reset period", period_o, 0);
        check("reset valid", period_valid_o, 0);
        check("reset timeout", timeout_o, 0);
        rstn_i = 1'b1;

        // 100-cycle reference on channel 0: first period on 2nd edge, lock on 6th.
        @(posedge clk_i);
        en[0] = 1;
        wait_pulse(0, 400, cyc);
        check("first pulse latency", cyc, 104);
        check("first period", period_o[W-1:0], 100);
        check("lock on first pulse", lock_o[0], 0);
        for (int p = 2; p <= 5; p++) begin
            wait_pulse(0, 200, cyc);
            check($sformatf("lock at pulse %0d", p), lock_o[0], (p == 5));
            check("idle channel lock", lock_o[1], 0);
        end

        // Small excursions hold lock; a 3-cycle jump drops it; 4 matches relock.
        @(posedge clk_i);
        fq0.push_back(101); fq0.push_back(100); fq0.push_back(99); fq0.push_back(102);
        per[0] = 102;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            wait_pulse(0, 200, cyc);
            found = (period_o[W-1:0] == 101);
        end
        check("saw period 101", found, 1);
        check("lock at 101", lock_o[0], 1);
        wait_pulse(0, 200, cyc);
        check("period 100", period_o[W-1:0], 100);
        check("lock at 100", lock_o[0], 1);
        wait_pulse(0, 200, cyc);
        check("period 99", period_o[W-1:0], 99);
        check("lock at 99", lock_o[0], 1);
        wait_pulse(0, 200, cyc);
        check("period 102", period_o[W-1:0], 102);
        check("lock drops at 102", lock_o[0], 0);
        for (int p = 1; p <= 4; p++) begin
            wait_pulse(0, 200, cyc);
            check($sformatf("relock match %0d", p), lock_o[0], (p == 4));
        end

        // Stop the reference: timeout exactly TMO cycles after the last edge.
        wait_pulse(0, 200, cyc);
        en[0] = 0;
        cyc = 0;
        while (!timeout_o[0] && cyc < 1500) begin
            @(negedge clk_i);
            cyc++;
        end
        check("timeout distance", cyc, 1000);
        check("lock after timeout", lock_o[0], 0);
        @(posedge clk_i);
        per[0] = 100;
        en[0]  = 1;
        for (int p = 0; p < 3; p++) wait_pulse(0, 300, cyc);
        check("timeout sticky", timeout_o[0], 1);
        clear_i[0] = 1'b1;
        @(negedge clk_i);
        clear_i[0] = 1'b0;
        check("timeout cleared", timeout_o[0], 0);

        // Both channels: 100 steady and 64 with +/-1 jitter.
        @(posedge clk_i);
        per[1] = 64; jit[1] = 1; en[1] = 1;
        cyc = 0;
        while (lock_o != 2'b11 && cyc < 20000) begin
            @(negedge clk_i);
            cyc++;
            if (period_valid_o[1])
                check("ch1 period in 63..65",
                      (period_o[W +: W] >= 63) && (period_o[W +: W] <= 65), 1);
            if (period_valid_o[0]) check("ch0 period", period_o[W-1:0], 100);
        end
        check("both locked", lock_o, 3);

        // One-cycle reset while locked.
        wait_pulse(0, 200, cyc);
        repeat (10) @(negedge clk_i);
        check("locked before reset", lock_o[0], 1);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        check("post-reset lock", lock_o, 0);
        check("post-reset period", period_o, 0);
        check("post-reset valid", period_valid_o, 0);
        check("post-reset timeout", timeout_o, 0);
        for (int p = 1; p <= 5; p++) begin
            wait_pulse(0, 300, cyc);
            check($sformatf("post-reset lock at pulse %0d", p), lock_o[0], (p == 5));
        end

        // Clear in the edge-detect cycle swallows that edge.
        prev_r = ref_i[0];
        found  = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk_i);
            if (ref_i[0] && !prev_r) found = 1'b1;
            prev_r = ref_i[0];
        end
        check("saw ch0 rise", found, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        clear_i[0] = 1'b1;
        @(negedge clk_i);
        clear_i[0] = 1'b0;
        check("no pulse on cleared edge", period_valid_o[0], 0);
        check("lock after clear", lock_o[0], 0);
        wait_pulse(0, 400, cyc);
        check("pulse after clear", cyc, 200);
        check("period after clear", period_o[W-1:0], 100);

        // Randomized phase: random periods, jitter, gaps and clears.
        for (int r = 0; r < 8; r++) begin
            @(posedge clk_i);
            for (int c = 0; c < CH; c++) begin
                per[c] = $urandom_range(16, 300);
                jit[c] = $urandom_range(0, 1);
                en[c]  = ($urandom_range(0, 4) != 0) ? 1 : 0;
            end
            len = $urandom_range(400, 1500);
            if (r == 2) begin
                per[0] = TMO; jit[0] = 1; en[0] = 1;
                len = 4000;
            end
            cl   = $urandom_range(0, len - 1);
            clch = $urandom_range(0, CH - 1);
            for (int i = 0; i < len; i++) begin
                @(negedge clk_i);
                clear_i = (i == cl) ? CH'(1 << clch) : '0;
            end
            clear_i = '0;
        end

        repeat (20) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
